// File: rtl/add_arb_pkg.sv
// -----------------------------------------------------------------------------
// add_arb_pkg
// Shared types and width helpers for the round-robin accumulating-adder
// scheduler (add_arb_n_m) and its round-robin picker (rr_pick_n).
//   state_e : scheduler FSM states
//   id_w()  : width of a requester index for R requesters
//   cnt_w() : width of the in-burst word counter for M words
// -----------------------------------------------------------------------------
package add_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index width for n items, never below 1 bit so ports stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int id_w(input int r);
    return idx_w(r);
  endfunction

  function automatic int cnt_w(input int m);
    return idx_w(m);
  endfunction

endpackage

// File: rtl/rr_pick_n.sv
// -----------------------------------------------------------------------------
// rr_pick_n
// Combinational round-robin picker. Returns the first asserted request found
// when searching ptr_i, ptr_i+1, ... wrapping modulo R.
//   req_i [R]    : request vector
//   ptr_i [ID_W] : search start position (must be < R)
//   any_o        : at least one request is asserted
//   idx_o [ID_W] : winning index (only meaningful when any_o=1)
// -----------------------------------------------------------------------------
module rr_pick_n
  import add_arb_pkg::*;
#(
  parameter  int R    = 4,
  localparam int ID_W = id_w(R)
) (
  input  logic [R-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic            any_o,
  output logic [ID_W-1:0] idx_o
);

  // Position k steps after base, wrapped into 0..R-1.
  function automatic logic [ID_W-1:0] rot(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= R) s = s - R;
    return ID_W'(s);
  endfunction

  always_comb begin
    any_o = |req_i;
    idx_o = ptr_i;
    // Scan from the farthest candidate back towards ptr so the nearest wins.
    for (int k = R - 1; k >= 0; k--) begin
      if (req_i[rot(ptr_i, k)]) idx_o = rot(ptr_i, k);
    end
  end

endmodule

// File: rtl/add_arb_n_m.sv
// -----------------------------------------------------------------------------
// add_arb_n_m
// Round-robin scheduler sharing one N-bit accumulating adder among R
// requesters. A granted requester hands over exactly M words, one per ack_o
// handshake; the words are summed with a carry that is sticky across the
// burst, and the result is offered on a valid/ready port tagged with the
// requester id.
//   clk_i, rst_i  : clock (rising edge), asynchronous active-high reset
//   req_i  [R]    : per-requester word-valid
//   data_i [R][N] : per-requester word
//   ack_o  [R]    : one-hot, word on data_i[r] consumed this cycle
//   busy_o        : a burst is in progress or its result is pending
//   sum_o  [N]    : burst sum (low N bits), valid with valid_o
//   c_o           : sticky carry-out of the burst
//   id_o          : requester that produced the result
//   valid_o       : result available
//   ready_i       : consumer accepts the result when valid_o & ready_i
// -----------------------------------------------------------------------------
module add_arb_n_m
  import add_arb_pkg::*;
#(
  parameter  int N     = 32,
  parameter  int M     = 4,
  parameter  int R     = 4,
  localparam int ID_W  = id_w(R),
  localparam int CNT_W = cnt_w(M)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [R-1:0]    req_i,
  input  logic [N-1:0]    data_i [0:R-1],
  output logic [R-1:0]    ack_o,
  output logic            busy_o,
  output logic [N-1:0]    sum_o,
  output logic            c_o,
  output logic [ID_W-1:0] id_o,
  output logic            valid_o,
  input  logic            ready_i
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N-1:0]      acc_q, acc_d;
  logic              carry_q, carry_d;

  logic              any_req;
  logic [ID_W-1:0]   winner;
  logic              accept;
  logic              last_word;
  logic [N:0]        sum_ext;

  rr_pick_n #(
    .R (R)
  ) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .any_o (any_req),
    .idx_o (winner)
  );

  // A word is consumed only from the granted requester while in BUSY; other
  // requesters are invisible until the scheduler returns to IDLE.
  assign accept    = (state_q == BUSY) && req_i[gnt_q];
  assign last_word = (cnt_q == CNT_W'(M - 1));
  assign sum_ext   = {1'b0, acc_q} + {1'b0, data_i[gnt_q]};

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req)             state_d = BUSY;
      BUSY:    if (accept && last_word) state_d = DONE;
      DONE:    if (ready_i)             state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ack_o   = '0;
    busy_o  = (state_q != IDLE);
    valid_o = (state_q == DONE);
    sum_o   = '0;
    c_o     = 1'b0;
    id_o    = '0;
    if (state_q == BUSY) ack_o[gnt_q] = req_i[gnt_q];
    if (state_q == DONE) begin
      sum_o = acc_q;
      c_o   = carry_q;
      id_o  = gnt_q;
    end
  end

  // Datapath next-state: grant capture, accumulation, counter, pointer
  always_comb begin
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = winner;
          cnt_d   = '0;
          acc_d   = '0;
          carry_d = 1'b0;
        end
      end
      BUSY: begin
        if (accept) begin
          acc_d   = sum_ext[N-1:0];
          carry_d = carry_q | sum_ext[N];
          cnt_d   = last_word ? '0 : cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // The requester just served drops to the back of the rotation.
        if (ready_i) ptr_d = (gnt_q == ID_W'(R - 1)) ? '0 : gnt_q + ID_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_add_arb_n_m.sv
module tb_add_arb_n_m;

  localparam int N  = 8;
  localparam int M  = 4;
  localparam int R  = 4;
  localparam int IW = 2;
  localparam int QD = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [R-1:0]  req = '0;
  logic [N-1:0]  data [0:R-1];
  logic          ready = 1'b1;
  logic [R-1:0]  ack_o;
  logic          busy_o;
  logic [N-1:0]  sum_o;
  logic          c_o;
  logic [IW-1:0] id_o;
  logic          valid_o;

  always #5 clk = ~clk;

  add_arb_n_m #(.N(N), .M(M), .R(R)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .data_i  (data),
    .ack_o   (ack_o),
    .busy_o  (busy_o),
    .sum_o   (sum_o),
    .c_o     (c_o),
    .id_o    (id_o),
    .valid_o (valid_o),
    .ready_i (ready)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- requester driver: per-requester word queues -------------
  logic [N-1:0] wbuf [R][QD];
  int head [R];
  int tail [R];
  int popped [R];
  int stall_at [R];
  int stall_len [R];
  int hold_cnt [R];
  logic [R-1:0] ack_s;

  initial begin
    for (int r = 0; r < R; r++) begin
      head[r] = 0; tail[r] = 0; popped[r] = 0;
      stall_at[r] = -1; stall_len[r] = 0; hold_cnt[r] = 0;
      data[r] = '0;
    end
    forever begin
      @(negedge clk);
      ack_s = ack_o;
      @(posedge clk);
      #1;
      for (int r = 0; r < R; r++) begin
        if (ack_s[r]) begin
          head[r]++;
          popped[r]++;
          if (popped[r] == stall_at[r]) hold_cnt[r] = stall_len[r];
        end
        if (hold_cnt[r] > 0) begin
          req[r] = 1'b0;
          hold_cnt[r]--;
        end else begin
          req[r] = (tail[r] > head[r]);
        end
        data[r] = (tail[r] > head[r]) ? wbuf[r][head[r]] : '0;
      end
    end
  end

  // ---------------- behavioural model + per-cycle compare -------------------
  int   m_owner = -1;
  int   m_total = 0;
  int   m_got   = 0;
  int   m_ptr   = 0;
  bit   m_res   = 1'b0;
  logic [R-1:0] s_req;
  logic [N-1:0] s_data [0:R-1];
  logic         s_ready;

  initial begin
    logic [R-1:0] e_ack;
    bit found;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_owner = -1; m_total = 0; m_got = 0; m_ptr = 0; m_res = 1'b0;
      end
      e_ack = '0;
      if (m_owner >= 0 && !m_res && req[IW'(m_owner)]) e_ack[IW'(m_owner)] = 1'b1;
      check("model_ack", 32'(ack_o), 32'(e_ack));
      check("model_busy", 32'(busy_o), 32'(m_owner >= 0));
      check("model_valid", 32'(valid_o), 32'(m_res));
      if (m_res) begin
        check("model_sum", 32'(sum_o), 32'(m_total % (1 << N)));
        check("model_c", 32'(c_o), 32'(m_total >= (1 << N)));
        check("model_id", 32'(id_o), 32'(m_owner));
      end
      s_req = req;
      s_ready = ready;
      for (int r = 0; r < R; r++) s_data[r] = data[r];
      @(posedge clk);
      if (!rst) begin
        if (m_owner < 0) begin
          found = 1'b0;
          for (int k = 0; k < R; k++) begin
            if (!found && s_req[IW'((m_ptr + k) % R)]) begin
              found = 1'b1;
              m_owner = (m_ptr + k) % R;
              m_total = 0;
              m_got = 0;
            end
          end
        end else if (!m_res) begin
          if (s_req[IW'(m_owner)]) begin
            m_total = m_total + int'(s_data[IW'(m_owner)]);
            m_got++;
            if (m_got == M) m_res = 1'b1;
          end
        end else if (s_ready) begin
          m_ptr = (m_owner + 1) % R;
          m_owner = -1;
          m_res = 1'b0;
        end
      end
    end
  end

  // ---------------- result log and ack counters ------------------------------
  logic [N-1:0] res_sum [QD];
  logic         res_c   [QD];
  int           res_id  [QD];
  int           nres = 0;
  int           ack_cnt [R];

  initial begin
    for (int r = 0; r < R; r++) ack_cnt[r] = 0;
    forever begin
      @(negedge clk);
      for (int r = 0; r < R; r++) if (ack_o[r]) ack_cnt[r]++;
      if (!rst && valid_o && ready && nres < QD) begin
        res_sum[nres] = sum_o;
        res_c[nres]   = c_o;
        res_id[nres]  = int'(id_o);
        nres++;
      end
    end
  end

  // ---------------- stimulus helpers -----------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int r, input logic [N-1:0] w);
    wbuf[r][tail[r]] = w;
    tail[r]++;
  endtask

  task automatic flush_all();
    for (int r = 0; r < R; r++) begin
      head[r] = 0; tail[r] = 0;
    end
  endtask

  task automatic wait_results(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (nres < n && c < budget) begin
      tick();
      c++;
    end
    check(name, 32'(nres), 32'(n));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   32'(ack_o),   32'h0);
    check({tag, "_busy"},  32'(busy_o),  32'h0);
    check({tag, "_valid"}, 32'(valid_o), 32'h0);
    check({tag, "_sum"},   32'(sum_o),   32'h0);
    check({tag, "_c"},     32'(c_o),     32'h0);
    check({tag, "_id"},    32'(id_o),    32'h0);
  endtask

  // ---------------- directed scenarios ----------------------------------------
  initial begin
    int c;
    int c2_before;
    logic [R-1:0] exp_ack;

    #12;
    check_all_zero("reset");
    #10;
    rst = 1'b0;
    tick();

    // Fairness: requesters 0 and 2 keep requesting, two bursts each.
    nres = 0;
    for (int i = 1; i <= 8; i++) push(0, N'(i));
    for (int i = 0; i < 4; i++) push(2, 8'h11);
    for (int i = 0; i < 4; i++) push(2, 8'h22);
    wait_results(4, 80, "fair_count");
    check("fair_id0", 32'(res_id[0]), 0);
    check("fair_id1", 32'(res_id[1]), 2);
    check("fair_id2", 32'(res_id[2]), 0);
    check("fair_id3", 32'(res_id[3]), 2);
    check("fair_sum0", 32'(res_sum[0]), 32'h0A);
    check("fair_sum1", 32'(res_sum[1]), 32'h44);
    check("fair_sum2", 32'(res_sum[2]), 32'h1A);
    check("fair_sum3", 32'(res_sum[3]), 32'h88);
    check("fair_ack1_never", 32'(ack_cnt[1]), 0);
    check("fair_ack3_never", 32'(ack_cnt[3]), 0);
    flush_all();

    // Basic burst from requester 1 with cycle-exact handshake timing.
    nres = 0;
    push(1, 8'h10); push(1, 8'h20); push(1, 8'h30); push(1, 8'h40);
    @(posedge clk);
    for (int cyc = 0; cyc <= 5; cyc++) begin
      @(negedge clk);
      exp_ack = (cyc >= 1 && cyc <= 4) ? 4'b0010 : 4'b0000;
      check($sformatf("t1_ack_cyc%0d", cyc), 32'(ack_o), 32'(exp_ack));
      check($sformatf("t1_valid_cyc%0d", cyc), 32'(valid_o), 32'(cyc == 5));
      if (cyc == 5) begin
        check("t1_sum", 32'(sum_o), 32'hA0);
        check("t1_c", 32'(c_o), 0);
        check("t1_id", 32'(id_o), 1);
      end
    end
    tick();
    flush_all();

    // Overflow sets c_o; the next burst starts with a clear carry.
    nres = 0;
    push(0, 8'hFF); push(0, 8'h01); push(0, 8'h00); push(0, 8'h00);
    for (int i = 0; i < 4; i++) push(0, 8'h01);
    wait_results(2, 40, "ovf_count");
    check("ovf_sum", 32'(res_sum[0]), 32'h00);
    check("ovf_c", 32'(res_c[0]), 1);
    check("ovf_id", 32'(res_id[0]), 0);
    check("clr_sum", 32'(res_sum[1]), 32'h04);
    check("clr_c", 32'(res_c[1]), 0);
    flush_all();

    // Stall after the 2nd word, then backpressure in DONE. Requester 0 also
    // requests and must wait until requester 2's result is taken.
    nres = 0;
    ready = 1'b0;
    c2_before = ack_cnt[2];
    popped[2] = 0;
    stall_at[2] = 2;
    stall_len[2] = 3;
    push(2, 8'h05); push(2, 8'h06); push(2, 8'h07); push(2, 8'h08);
    push(0, 8'h01); push(0, 8'h02); push(0, 8'h03); push(0, 8'h04);
    c = 0;
    @(negedge clk);
    while (!valid_o && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("bp_valid_seen", 32'(valid_o), 1);
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", 32'(valid_o), 1);
      check("bp_sum", 32'(sum_o), 32'h1A);
      check("bp_id", 32'(id_o), 2);
      check("bp_noack", 32'(ack_o), 0);
      if (i < 3) @(negedge clk);
    end
    tick();
    ready = 1'b1;
    stall_at[2] = -1;
    wait_results(2, 40, "bp_count");
    check("bp_res0_sum", 32'(res_sum[0]), 32'h1A);
    check("bp_res0_id", 32'(res_id[0]), 2);
    check("bp_res1_sum", 32'(res_sum[1]), 32'h0A);
    check("bp_res1_id", 32'(res_id[1]), 0);
    check("bp_acks_r2", 32'(ack_cnt[2] - c2_before), 4);
    flush_all();

    // Asynchronous reset after two accepted words aborts the burst.
    nres = 0;
    push(1, 8'h11); push(1, 8'h22); push(1, 8'h33); push(1, 8'h44);
    c = 0;
    while ((tail[1] - head[1]) > 2 && c < 20) begin
      tick();
      c++;
    end
    check("rst_two_acked", 32'(tail[1] - head[1]), 2);
    check("rst_busy_before", 32'(busy_o), 1);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    flush_all();
    tick();
    tick();
    rst = 1'b0;
    tick();
    push(3, 8'h03); push(3, 8'h05); push(3, 8'h07); push(3, 8'h09);
    wait_results(1, 40, "rst_count");
    check("rst_sum", 32'(res_sum[0]), 32'h18);
    check("rst_c", 32'(res_c[0]), 0);
    check("rst_id", 32'(res_id[0]), 3);
    for (int i = 0; i < 5; i++) tick();
    check("rst_no_extra", 32'(nres), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/add_arb_n_m.md
Name: add_arb_n_m

Overview:
Round-robin scheduler that shares one n-bit accumulating adder among R requesters. Each requester submits a burst of exactly M words. The block grants one requester at a time and accumulates that requester's M words, carry sticky across the burst. It then presents the sum, sticky carry and requester id on a valid/ready result port. It sits in front of the multi-word summing datapath and replaces its free-running input shift with per-word handshakes.

Parameters:
N, 32, data/sum width in bits
M, 4, words per burst (M >= 2)
R, 4, number of requesters (R >= 2)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
req_i  in  R  req_i[r]=1: data_i[r] holds a valid word from requester r
data_i  in  N x [0:R-1]  unpacked array of per-requester words
ack_o  out  R  one-hot; ack_o[r]=1: word on data_i[r] consumed this cycle
busy_o  out  1  1 while state != IDLE
sum_o  out  N  accumulated sum, valid when valid_o=1
c_o  out  1  sticky carry-out of the burst
id_o  out  clog2(R)  requester index of the result
valid_o  out  1  result available
ready_i  in  1  result consumer accepts when valid_o&ready_i

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous, active-high.
- Reset values: state=IDLE, ptr=0, gnt_id=0, cnt=0, acc=0, carry=0. Outputs: ack_o=0, busy_o=0, valid_o=0, sum_o=0, c_o=0, id_o=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Winner = first r with req_i[r]=1, searching ptr, ptr+1, ..., wrapping mod R.
  - If any req_i is set: gnt_id<=winner, cnt<=0, acc<=0, carry<=0, go to BUSY.
  - No ack_o in IDLE, so the first word is accepted one cycle after the request is seen.
- BUSY:
  - ack_o[gnt_id]=req_i[gnt_id], combinational. All other ack_o bits are 0.
  - On accept: {co,acc}<=acc+data_i[gnt_id] (N+1-bit add), carry<=carry|co, cnt<=cnt+1.
  - Accept with cnt==M-1: go to DONE and clear cnt.
  - req_i[gnt_id]=0 stalls the burst. No accept, acc/cnt hold, the grant is kept, and there is no timeout.
  - req_i of other requesters is ignored during BUSY.
- DONE:
  - valid_o=1, sum_o=acc, c_o=carry, id_o=gnt_id. Outputs stay stable while ready_i=0.
  - On ready_i=1: ptr<=(gnt_id+1) mod R, go to IDLE.
  - No ack_o in DONE.
- Wrap-around:
  - ptr wraps from R-1 to 0.
  - cnt counts 0..M-1 in a clog2(M)-bit register.
  - acc overflow is reported only through c_o. acc keeps the low N bits.
- Minimum burst cycle: 1 (IDLE) + M (BUSY) + 1 (DONE with ready_i=1) = M+2 cycles per result.
- Reset mid-burst aborts the burst immediately. The partial sum is discarded and no result is produced.
- A requester that deasserts after its last ack has no effect. A requester that keeps req_i high is granted its next burst only when its round-robin turn comes.

Decomposition:
- Package add_arb_pkg:
  - state enum (IDLE, BUSY, DONE)
  - localparam helpers for id width clog2(R) and count width clog2(M)
- Sub-module rr_pick_n:
  - combinational round-robin picker, params R
  - inputs req_i and ptr; outputs any_o and idx_o
  - reused by other schedulers
- Accumulator, counter and FSM stay in add_arb_n_m.

Test Plan:
- N=8, M=4. req_i[1] held high with words 0x10,0x20,0x30,0x40 and ready_i=1 -> ack_o[1] high cycles 1-4, valid_o in cycle 5 with sum_o=0xA0, c_o=0, id_o=1.
- Overflow: requester 0 sends 0xFF,0x01,0x00,0x00 -> sum_o=0x00, c_o=1. The next burst 0x01 x4 -> c_o=0, i.e. carry is cleared per burst.
- Fairness: req_i[0] and req_i[2] held high continuously with ready_i=1 -> result id_o sequence 0,2,0,2. Requesters 1 and 3 are never acked.
- Stall and backpressure: drop req_i[gnt] for 3 cycles after the 2nd word -> ack_o=0 and the final sum is unchanged. Then hold ready_i=0 for 4 cycles in DONE -> valid_o, sum_o and id_o remain stable, and no ack_o occurs.
- Reset mid-burst: assert rst_i asynchronously (between clock edges) after 2 accepted words -> all outputs go to 0 immediately. After release, a fresh burst from requester 3 sums only its own 4 words and gets id_o=3.
